// File: rtl/hazard_unit.sv
// hazard_unit: load-use/shadow-stage interlock, E-stage forwarding, branch flush and stall monitoring.
module hazard_unit #(
    parameter int WB_BYPASS = 0,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       srcAdd1,
    input  logic [3:0]       srcAdd2,
    input  logic             immediateC,
    input  logic             InstBranch,
    input  logic             RegWriteE,
    input  logic             MemToRegE,
    input  logic [3:0]       destAddE,
    output logic             stallF,
    output logic             stallD,
    output logic             forwardA,
    output logic             forwardB,
    output logic             flushD,
    output logic             flushC,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic             hazard_err
);
    typedef enum logic {RUN, STALL} state_t;
    localparam bit CHECK_W = (WB_BYPASS == 0);
    state_t           state_q;
    logic             vm_q, vw_q, err_q;
    logic [3:0]       dm_q, dw_q;
    logic [2:0]       stall_len_q;
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
    logic             op2, em1, em2, hz1, hz2, hazard, flush_br;
    assign op2      = !immediateC;
    assign em1      = RegWriteE && destAddE == srcAdd1;
    assign em2      = op2 && RegWriteE && destAddE == srcAdd2;
    assign hz1      = (em1 && MemToRegE) || (vm_q && dm_q == srcAdd1) || (CHECK_W && vw_q && dw_q == srcAdd1);
    assign hz2      = op2 && ((em2 && MemToRegE) || (vm_q && dm_q == srcAdd2) || (CHECK_W && vw_q && dw_q == srcAdd2));
    assign hazard   = hz1 || hz2;
    assign flush_br = !hazard && InstBranch;
    // Control outputs fall back to "advance, no forward, no flush" while reset is held.
    assign stallF     = !reset || !hazard;
    assign stallD     = !reset || !hazard;
    assign forwardA   = reset && !hazard && em1 && !MemToRegE;
    assign forwardB   = reset && !hazard && em2 && !MemToRegE;
    assign flushD     = reset && flush_br;
    assign flushC     = reset && hazard;
    assign stall_cnt  = stall_cnt_q;
    assign flush_cnt  = flush_cnt_q;
    assign hazard_err = err_q;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vm_q        <= 1'b0;
            vw_q        <= 1'b0;
            dm_q        <= '0;
            dw_q        <= '0;
            state_q     <= RUN;
            stall_len_q <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            err_q       <= 1'b0;
        end else begin
            vm_q <= RegWriteE;
            dm_q <= destAddE;
            vw_q <= vm_q;
            dw_q <= dm_q;
            if (hazard && !(&stall_cnt_q)) stall_cnt_q <= stall_cnt_q + 1'b1;
            if (flush_br && !(&flush_cnt_q)) flush_cnt_q <= flush_cnt_q + 1'b1;
            // stall_len holds the number of hazard cycles already completed; bit 2 is overflow.
            case (state_q)
                RUN: if (hazard) begin
                    state_q     <= STALL;
                    stall_len_q <= 3'd1;
                end
                STALL: if (hazard) begin
                    stall_len_q <= stall_len_q[2] ? stall_len_q : stall_len_q + 3'd1;
                    if (stall_len_q >= 3'd3) err_q <= 1'b1;
                end else begin
                    state_q     <= RUN;
                    stall_len_q <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: directed vectors against a no-bypass instance and a bypass instance with 2-bit counters.
module tb_hazard_unit;
    logic clk = 1'b0, reset = 1'b0;
    logic [3:0] s1 = '0, s2 = '0, dst = '0;
    logic imm = 1'b0, br = 1'b0, rw = 1'b0, m2r = 1'b0;
    logic sf0, sd0, fa0, fb0, fd0, fc0, err0;
    logic sf1, sd1, fa1, fb1, fd1, fc1, err1;
    logic [15:0] sc0, fcn0;
    logic [1:0] sc1, fcn1;
    logic [5:0] ctl0, ctl1;
    int checks = 0, failures = 0;
    localparam logic [5:0] RUN_C = 6'b110000, HAZ_C = 6'b000001, BR_C = 6'b110010;
    assign ctl0 = {sf0, sd0, fa0, fb0, fd0, fc0};
    assign ctl1 = {sf1, sd1, fa1, fb1, fd1, fc1};
    always #5 clk = ~clk;
    hazard_unit #(.WB_BYPASS(0), .CNT_W(16)) dut0 (
        .clk(clk), .reset(reset), .srcAdd1(s1), .srcAdd2(s2), .immediateC(imm),
        .InstBranch(br), .RegWriteE(rw), .MemToRegE(m2r), .destAddE(dst),
        .stallF(sf0), .stallD(sd0), .forwardA(fa0), .forwardB(fb0), .flushD(fd0),
        .flushC(fc0), .stall_cnt(sc0), .flush_cnt(fcn0), .hazard_err(err0));
    hazard_unit #(.WB_BYPASS(1), .CNT_W(2)) dut1 (
        .clk(clk), .reset(reset), .srcAdd1(s1), .srcAdd2(s2), .immediateC(imm),
        .InstBranch(br), .RegWriteE(rw), .MemToRegE(m2r), .destAddE(dst),
        .stallF(sf1), .stallD(sd1), .forwardA(fa1), .forwardB(fb1), .flushD(fd1),
        .flushC(fc1), .stall_cnt(sc1), .flush_cnt(fcn1), .hazard_err(err1));
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    task automatic put(input logic [3:0] a, input logic [3:0] b, input logic i, input logic bb,
                       input logic w, input logic m, input logic [3:0] d);
        s1 = a; s2 = b; imm = i; br = bb; rw = w; m2r = m; dst = d;
        #2;
    endtask
    task automatic nxt;
        @(posedge clk);
        #1;
    endtask
    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            put(0, 0, 0, 0, 0, 0, 0);
            nxt();
        end
    endtask
    initial begin
        put(4, 0, 0, 1, 1, 1, 4);
        nxt();
        chk("rst_ctl0", ctl0, RUN_C);
        chk("rst_ctl1", ctl1, RUN_C);
        chk("rst_scnt", sc0, 0);
        chk("rst_fcnt", fcn0, 0);
        chk("rst_err", err0, 0);
        put(0, 0, 0, 0, 0, 0, 0);
        nxt();
        reset = 1'b1;
        put(3, 5, 0, 0, 1, 0, 3);
        chk("fwdA_0", ctl0, 6'b111000);
        chk("fwdA_1", ctl1, 6'b111000);
        nxt();
        put(5, 6, 0, 0, 1, 0, 6);
        chk("fwdB", ctl0, 6'b110100);
        nxt();
        put(5, 9, 1, 0, 1, 0, 9);
        chk("fwdB_imm", ctl0, RUN_C);
        nxt();
        put(10, 10, 0, 0, 1, 0, 10);
        chk("fwdAB", ctl1, 6'b111100);
        nxt();
        idle(3);
        put(0, 4, 0, 0, 1, 1, 4);
        chk("lu1_0", ctl0, HAZ_C);
        chk("lu1_1", ctl1, HAZ_C);
        nxt();
        put(0, 4, 0, 0, 0, 0, 0);
        chk("lu2_0", ctl0, HAZ_C);
        chk("lu2_1", ctl1, HAZ_C);
        nxt();
        chk("lu3_0", ctl0, HAZ_C);
        chk("lu3_1", ctl1, RUN_C);
        nxt();
        chk("lu4_0", ctl0, RUN_C);
        chk("lu_scnt0", sc0, 3);
        chk("lu_scnt1", sc1, 2);
        chk("lu_err", err0, 0);
        nxt();
        idle(2);
        put(0, 4, 1, 0, 1, 1, 4);
        chk("imm_e", ctl0, RUN_C);
        nxt();
        put(0, 4, 1, 0, 0, 0, 0);
        chk("imm_m", ctl0, RUN_C);
        nxt();
        chk("imm_w", ctl0, RUN_C);
        nxt();
        idle(2);
        put(0, 0, 0, 1, 0, 0, 0);
        chk("br_ctl", ctl0, BR_C);
        nxt();
        put(0, 0, 0, 0, 0, 0, 0);
        chk("br_fcnt", fcn0, 1);
        nxt();
        put(0, 4, 0, 1, 1, 1, 4);
        chk("brlu1", ctl0, HAZ_C);
        nxt();
        put(0, 4, 0, 1, 0, 0, 0);
        chk("brlu2", ctl0, HAZ_C);
        nxt();
        chk("brlu3_0", ctl0, HAZ_C);
        chk("brlu3_1", ctl1, BR_C);
        chk("brlu3_fcnt", fcn0, 1);
        nxt();
        chk("brlu4", ctl0, BR_C);
        nxt();
        put(0, 0, 0, 0, 0, 0, 0);
        chk("brlu_fcnt0", fcn0, 2);
        chk("sat_fcnt1", fcn1, 3);
        chk("sat_scnt1", sc1, 3);
        chk("brlu_scnt0", sc0, 6);
        nxt();
        idle(1);
        put(0, 0, 0, 0, 1, 0, 7);
        chk("alu_e", ctl0, RUN_C);
        nxt();
        put(7, 0, 0, 0, 1, 0, 9);
        chk("vm_0", ctl0, HAZ_C);
        chk("vm_1", ctl1, HAZ_C);
        nxt();
        idle(2);
        put(0, 0, 0, 0, 1, 0, 7);
        nxt();
        put(0, 0, 0, 0, 1, 0, 9);
        nxt();
        put(7, 0, 0, 0, 1, 0, 10);
        chk("vw_0", ctl0, HAZ_C);
        chk("vw_1", ctl1, RUN_C);
        nxt();
        put(7, 0, 0, 0, 0, 0, 0);
        chk("vw_after", ctl0, RUN_C);
        nxt();
        idle(2);
        chk("alu_scnt0", sc0, 8);
        put(4, 0, 0, 0, 1, 1, 4);
        for (int k = 1; k <= 4; k++) begin
            chk("force_ctl", ctl0, HAZ_C);
            chk("force_err", err0, 0);
            nxt();
        end
        chk("err_set0", err0, 1);
        chk("err_set1", err1, 1);
        nxt();
        put(0, 0, 0, 0, 0, 0, 0);
        chk("err_ctl", ctl0, RUN_C);
        nxt();
        chk("err_sticky", err0, 1);
        put(4, 0, 0, 0, 1, 1, 4);
        chk("rehaz", ctl0, HAZ_C);
        #2 reset = 1'b0;
        #1;
        chk("mid_ctl0", ctl0, RUN_C);
        chk("mid_ctl1", ctl1, RUN_C);
        chk("mid_scnt", sc0, 0);
        chk("mid_fcnt", fcn0, 0);
        chk("mid_err", err0, 0);
        put(4, 0, 0, 0, 0, 0, 0);
        nxt();
        reset = 1'b1;
        #2;
        chk("post_rst0", ctl0, RUN_C);
        chk("post_rst1", ctl1, RUN_C);
        nxt();
        chk("post_scnt", sc0, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
